enthdr_target_detect: RTL and testbench

//  Target-side counterpart of the controller ENTHDR CCC sequencer. Watches the SDR bus bit stream
//  for broadcast address 7'h7E+W, ACKs it, captures the following CCC byte and T bit, checks parity
//  and, on a valid ENTHDRx CCC, switches the target into HDR mode. Sits between the target SCL/SDA

---
 rtl/enthdr_target_detect.sv | 152 +++++++++++++++
 tb/tb_enthdr_target_detect.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enthdr_target_detect.sv
// enthdr_target_detect: target-side ENTHDR CCC detector. Recognises broadcast
// address + W, ACKs it, checks the following CCC and T bit, and holds HDR mode until exit.
`default_nettype none

module enthdr_target_detect #(
    parameter logic [6:0] BCAST_ADDR    = 7'h7E,
    parameter logic [7:0] HDR_SUPPORTED = 8'b0000_0001
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start_det,
    input  logic       i_stop_det,
    input  logic       i_scl_rise,
    input  logic       i_scl_fall,
    input  logic       i_sda,
    input  logic       i_hdr_exit,
    output logic       o_sda_pull_low,
    output logic       o_hdr_en,
    output logic [2:0] o_hdr_mode,
    output logic       o_hdr_entered,
    output logic       o_parity_err
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ADDR      = 3'd1,
        S_ACK       = 3'd2,
        S_CCC       = 3'd3,
        S_TBIT      = 3'd4,
        S_WAIT_STOP = 3'd5,
        S_HDR       = 3'd6
    } state_t;

    state_t     state;
    logic [3:0] bit_cnt;
    logic [7:0] shift_reg;

    logic [7:0] shift_next;
    logic       in_frame;
    logic       parity_ok;
    logic       is_enthdr;
    logic       mode_ok;

    assign shift_next = {shift_reg[6:0], i_sda};
    // Bus conditions abort only the states that are actively decoding a frame.
    assign in_frame   = (state == S_ADDR) || (state == S_ACK) ||
                        (state == S_CCC)  || (state == S_TBIT);
    assign parity_ok  = ^{shift_reg, i_sda};
    assign is_enthdr  = (shift_reg[7:3] == 5'b00100);
    assign mode_ok    = HDR_SUPPORTED[shift_reg[2:0]];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state          <= S_IDLE;
            bit_cnt        <= 4'd0;
            shift_reg      <= 8'd0;
            o_sda_pull_low <= 1'b0;
            o_hdr_en       <= 1'b0;
            o_hdr_mode     <= 3'd0;
            o_hdr_entered  <= 1'b0;
            o_parity_err   <= 1'b0;
        end else begin
            o_hdr_entered <= 1'b0;
            o_parity_err  <= 1'b0;

            if (in_frame && i_stop_det) begin
                state          <= S_IDLE;
                o_sda_pull_low <= 1'b0;
            end else if (in_frame && i_start_det) begin
                state          <= S_ADDR;
                bit_cnt        <= 4'd0;
                shift_reg      <= 8'd0;
                o_sda_pull_low <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (i_start_det && !i_stop_det) begin
                            state     <= S_ADDR;
                            bit_cnt   <= 4'd0;
                            shift_reg <= 8'd0;
                        end
                    end
                    S_ADDR: begin
                        if (i_scl_rise) begin
                            shift_reg <= shift_next;
                            bit_cnt   <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                state <= (shift_next == {BCAST_ADDR, 1'b0}) ? S_ACK : S_WAIT_STOP;
                            end
                        end
                    end
                    S_ACK: begin
                        // First falling edge starts the ACK drive, the second ends it.
                        if (i_scl_fall) begin
                            if (!o_sda_pull_low) begin
                                o_sda_pull_low <= 1'b1;
                            end else begin
                                o_sda_pull_low <= 1'b0;
                                state          <= S_CCC;
                                bit_cnt        <= 4'd0;
                            end
                        end
                    end
                    S_CCC: begin
                        if (i_scl_rise) begin
                            shift_reg <= shift_next;
                            bit_cnt   <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                state <= S_TBIT;
                            end
                        end
                    end
                    S_TBIT: begin
                        if (i_scl_rise) begin
                            state <= S_WAIT_STOP;
                            if (is_enthdr && !parity_ok) begin
                                o_parity_err <= 1'b1;
                            end else if (is_enthdr && mode_ok) begin
                                state         <= S_HDR;
                                o_hdr_en      <= 1'b1;
                                o_hdr_mode    <= shift_reg[2:0];
                                o_hdr_entered <= 1'b1;
                            end
                        end
                    end
                    S_WAIT_STOP: begin
                        if (i_stop_det) begin
                            state <= S_IDLE;
                        end else if (i_start_det) begin
                            state     <= S_ADDR;
                            bit_cnt   <= 4'd0;
                            shift_reg <= 8'd0;
                        end
                    end
                    S_HDR: begin
                        if (i_hdr_exit) begin
                            state      <= S_IDLE;
                            o_hdr_en   <= 1'b0;
                            o_hdr_mode <= 3'd0;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_enthdr_target_detect.sv
// tb_enthdr_target_detect: drives SDR bit sequences into two detector instances
// (default modes and modes 0/1) and scoreboards the entry / parity-error pulses.
`default_nettype none

module tb_enthdr_target_detect;

    localparam int P_START = 0;
    localparam int P_STOP  = 1;
    localparam int P_RISE  = 2;
    localparam int P_FALL  = 3;
    localparam int P_EXIT  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_det = 1'b0;
    logic       stop_det = 1'b0;
    logic       scl_rise = 1'b0;
    logic       scl_fall = 1'b0;
    logic       sda = 1'b1;
    logic       hdr_exit = 1'b0;

    logic       pull_a, en_a, entered_a, perr_a;
    logic [2:0] mode_a;
    logic       pull_b, en_b, entered_b, perr_b;
    logic [2:0] mode_b;

    int passed = 0;
    int total  = 0;
    int entered_b_cnt = 0;

    // Expected pulse events for instance A: {hdr_entered, parity_err, hdr_mode}
    logic [4:0] exp_q[$];

    always #5 clk = ~clk;

    enthdr_target_detect dut_a (
        .i_clk(clk), .i_rst(rst), .i_start_det(start_det), .i_stop_det(stop_det),
        .i_scl_rise(scl_rise), .i_scl_fall(scl_fall), .i_sda(sda), .i_hdr_exit(hdr_exit),
        .o_sda_pull_low(pull_a), .o_hdr_en(en_a), .o_hdr_mode(mode_a),
        .o_hdr_entered(entered_a), .o_parity_err(perr_a)
    );

    enthdr_target_detect #(.BCAST_ADDR(7'h7E), .HDR_SUPPORTED(8'h03)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_start_det(start_det), .i_stop_det(stop_det),
        .i_scl_rise(scl_rise), .i_scl_fall(scl_fall), .i_sda(sda), .i_hdr_exit(hdr_exit),
        .o_sda_pull_low(pull_b), .o_hdr_en(en_b), .o_hdr_mode(mode_b),
        .o_hdr_entered(entered_b), .o_parity_err(perr_b)
    );

    // Scoreboard consumer: every pulse from instance A must match the next expected event.
    always @(negedge clk) begin
        if (!rst && (entered_a || perr_a)) begin
            logic [4:0] obs;
            logic [4:0] e;
            obs = {entered_a, perr_a, mode_a};
            total++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_event got=%b required=none", obs);
            end else begin
                e = exp_q.pop_front();
                if (obs !== e) $display("FAIL event got=%b required=%b", obs, e);
                else passed++;
            end
        end
        if (!rst && entered_b) entered_b_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic pulse(input int which);
        case (which)
            P_START: start_det = 1'b1;
            P_STOP:  stop_det  = 1'b1;
            P_RISE:  scl_rise  = 1'b1;
            P_FALL:  scl_fall  = 1'b1;
            default: hdr_exit  = 1'b1;
        endcase
        @(posedge clk); #1;
        start_det = 1'b0; stop_det = 1'b0; scl_rise = 1'b0; scl_fall = 1'b0; hdr_exit = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_bit(input logic b);
        sda = b;
        pulse(P_RISE);
        idle(1);
        pulse(P_FALL);
        idle(1);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) begin
            sda = v[i];
            pulse(P_RISE);
            total++;
            if (pull_a !== 1'b0) $display("FAIL bit_no_drive got=%b required=0", pull_a);
            else passed++;
            idle(1);
            pulse(P_FALL);
            idle(1);
        end
    endtask

    task automatic ack_bit(input logic exp_drive);
        total++;
        if (pull_a !== exp_drive) $display("FAIL ack_drive got=%b required=%b", pull_a, exp_drive);
        else passed++;
        sda = 1'b1;
        pulse(P_RISE);
        total++;
        if (pull_a !== exp_drive) $display("FAIL ack_hold got=%b required=%b", pull_a, exp_drive);
        else passed++;
        idle(1);
        pulse(P_FALL);
        total++;
        if (pull_a !== 1'b0) $display("FAIL ack_release got=%b required=0", pull_a);
        else passed++;
        idle(1);
    endtask

    // Full ENTHDR frame towards the broadcast address.
    task automatic enthdr_frame(input logic [7:0] ccc, input logic t);
        pulse(P_START);
        idle(1);
        send_byte(8'hFC);
        ack_bit(1'b1);
        send_byte(ccc);
        send_bit(t);
    endtask

    task automatic test_reset;
        total++;
        if ({pull_a, en_a, mode_a, entered_a, perr_a} !== 7'd0)
            $display("FAIL reset_outputs got=%b required=0", {pull_a, en_a, mode_a, entered_a, perr_a});
        else passed++;
        rst = 1'b0;
        idle(2);
        // Reset while the target is driving ACK.
        pulse(P_START);
        idle(1);
        send_byte(8'hFC);
        total++;
        if (pull_a !== 1'b1) $display("FAIL pre_reset_ack got=%b required=1", pull_a);
        else passed++;
        #2 rst = 1'b1;
        #1;
        total++;
        if ({pull_a, en_a, mode_a, entered_a, perr_a, pull_b, en_b} !== 9'd0)
            $display("FAIL async_reset got=%b required=0",
                     {pull_a, en_a, mode_a, entered_a, perr_a, pull_b, en_b});
        else passed++;
        @(posedge clk); #1 rst = 1'b0;
        idle(1);
        // Without a START the detector must ignore an address byte.
        send_byte(8'hFC);
        total++;
        if (pull_a !== 1'b0) $display("FAIL idle_after_reset got=%b required=0", pull_a);
        else passed++;
        pulse(P_STOP);
        idle(2);
    endtask

    task automatic test_hdr_entry;
        exp_q.push_back({1'b1, 1'b0, 3'd0});
        enthdr_frame(8'h20, 1'b0);
        total++;
        if ({en_a, mode_a} !== {1'b1, 3'd0}) $display("FAIL hdr_entry got=%b required=1000", {en_a, mode_a});
        else passed++;
        pulse(P_EXIT);
        total++;
        if ({en_a, mode_a, en_b} !== 5'd0) $display("FAIL hdr_exit got=%b required=0", {en_a, mode_a, en_b});
        else passed++;
        idle(2);
    endtask

    task automatic test_parity_err;
        exp_q.push_back({1'b0, 1'b1, 3'd0});
        enthdr_frame(8'h20, 1'b1);
        idle(2);
        total++;
        if ({en_a, en_b} !== 2'b00) $display("FAIL parity_no_hdr got=%b required=00", {en_a, en_b});
        else passed++;
        pulse(P_STOP);
        idle(1);
        send_byte(8'hFC);
        total++;
        if (pull_a !== 1'b0) $display("FAIL parity_idle got=%b required=0", pull_a);
        else passed++;
        idle(2);
    endtask

    task automatic test_other_addr;
        pulse(P_START);
        idle(1);
        send_byte(8'hA4);
        ack_bit(1'b0);
        send_byte(8'h20);
        send_bit(1'b0);
        send_byte(8'hFC);
        total++;
        if ({pull_a, en_a, en_b} !== 3'b000) $display("FAIL other_addr got=%b required=000", {pull_a, en_a, en_b});
        else passed++;
        pulse(P_STOP);
        idle(2);
    endtask

    task automatic test_mode_support;
        int before_b;
        before_b = entered_b_cnt;
        enthdr_frame(8'h21, 1'b1);
        idle(2);
        total++;
        if (en_a !== 1'b0) $display("FAIL mode1_unsupported got=%b required=0", en_a);
        else passed++;
        total++;
        if ({en_b, mode_b} !== {1'b1, 3'd1}) $display("FAIL mode1_supported got=%b required=1001", {en_b, mode_b});
        else passed++;
        total++;
        if (entered_b_cnt - before_b !== 1) $display("FAIL mode1_pulse got=%0d required=1", entered_b_cnt - before_b);
        else passed++;
        pulse(P_STOP);
        pulse(P_EXIT);
        total++;
        if ({en_a, en_b, mode_b} !== 5'd0) $display("FAIL mode1_exit got=%b required=0", {en_a, en_b, mode_b});
        else passed++;
        idle(2);
    endtask

    task automatic test_restart;
        pulse(P_START);
        idle(1);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        exp_q.push_back({1'b1, 1'b0, 3'd0});
        enthdr_frame(8'h20, 1'b0);
        pulse(P_STOP);
        pulse(P_START);
        send_byte(8'hFC);
        total++;
        if ({en_a, mode_a, pull_a} !== {1'b1, 3'd0, 1'b0})
            $display("FAIL hdr_hold got=%b required=10000", {en_a, mode_a, pull_a});
        else passed++;
        pulse(P_EXIT);
        idle(2);
    endtask

    task automatic test_priority;
        pulse(P_START);
        idle(1);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        start_det = 1'b1;
        pulse(P_STOP);
        send_byte(8'hFC);
        total++;
        if (pull_a !== 1'b0) $display("FAIL stop_over_start got=%b required=0", pull_a);
        else passed++;
        idle(2);
    endtask

    task automatic test_back_to_back;
        exp_q.push_back({1'b1, 1'b0, 3'd0});
        enthdr_frame(8'h20, 1'b0);
        pulse(P_EXIT);
        exp_q.push_back({1'b1, 1'b0, 3'd0});
        enthdr_frame(8'h20, 1'b0);
        total++;
        if (en_a !== 1'b1) $display("FAIL b2b_entry got=%b required=1", en_a);
        else passed++;
        pulse(P_EXIT);
        idle(3);
        total++;
        if (exp_q.size() != 0) $display("FAIL missing_events got=%0d required=0", exp_q.size());
        else passed++;
    endtask

    initial begin
        @(posedge clk); #1;
        idle(2);
        test_reset();
        test_hdr_entry();
        test_parity_err();
        test_other_addr();
        test_mode_support();
        test_restart();
        test_priority();
        test_back_to_back();
        total++;
        if ({pull_b, perr_b} !== 2'b00) $display("FAIL b_idle got=%b required=00", {pull_b, perr_b});
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
